pp_stream_loader: RTL and testbench

//  Upstream feeder for the West-bank ping-pong buffers. Accepts a narrow valid/ready element stream
//  and packs beats into W_IN_WIDTH-wide words, one word per west input lane.

---
 rtl/pp_stream_loader_if.sv | 29 ++
 rtl/pp_stream_loader.sv | 119 +++++++++++
 tb/tb_pp_stream_loader.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pp_stream_loader_if.sv
// Stream-side and ping-pong-side signals of the West-bank loader.
// The slave modport is the loader itself; the master modport is whatever drives and consumes it.
interface pp_stream_loader_if #(
    parameter int DATA_WIDTH = 16,
    parameter int BEAT_ELEMS = 4,
    parameter int WORD_ELEMS = 8,
    parameter int LANES      = 2
);
    logic                                          s_valid;
    logic                                          s_ready;
    logic [BEAT_ELEMS*DATA_WIDTH-1:0]              s_data;
    logic                                          s_last;
    logic                                          load_ready;
    logic [LANES-1:0][WORD_ELEMS*DATA_WIDTH-1:0]   w_din;
    logic                                          din_valid;
    logic                                          tile_last;
    logic                                          frame_err;
    logic                                          busy;

    modport master (
        output s_valid, s_data, s_last, load_ready,
        input  s_ready, w_din, din_valid, tile_last, frame_err, busy
    );

    modport slave (
        input  s_valid, s_data, s_last, load_ready,
        output s_ready, w_din, din_valid, tile_last, frame_err, busy
    );
endinterface

// File: rtl/pp_stream_loader.sv
// Packs narrow stream beats into LANES lane words and hands each complete group to the
// ping-pong write side as a one-cycle din_valid pulse, checking tile framing against s_last.
module pp_stream_loader #(
    parameter int DATA_WIDTH      = 16,
    parameter int BEAT_ELEMS      = 4,
    parameter int WORD_ELEMS      = 8,
    parameter int LANES           = 2,
    parameter int GROUPS_PER_TILE = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    pp_stream_loader_if.slave       bus
);
    localparam int R      = WORD_ELEMS / BEAT_ELEMS;
    localparam int BEAT_W = BEAT_ELEMS * DATA_WIDTH;
    localparam int WORD_W = WORD_ELEMS * DATA_WIDTH;
    localparam int BCW    = (R > 1) ? $clog2(R) : 1;
    localparam int LCW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int GCW    = (GROUPS_PER_TILE > 1) ? $clog2(GROUPS_PER_TILE) : 1;

    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]                   state_q, state_d;
    logic [BCW-1:0]               beat_cnt_q, beat_cnt_d;
    logic [LCW-1:0]               lane_cnt_q, lane_cnt_d;
    logic [GCW-1:0]               group_cnt_q, group_cnt_d;
    logic [LANES-1:0][WORD_W-1:0] w_din_q, w_din_d;
    logic                         din_valid_q, din_valid_d;
    logic                         tile_last_q, tile_last_d;
    logic                         frame_err_q, frame_err_d;

    logic accept;
    logic beat_last;
    logic lane_last;
    logic group_last;
    logic expected_last;

    assign bus.s_ready   = !rst && (state_q == FILL);
    assign accept        = bus.s_valid && bus.s_ready;
    assign beat_last     = (beat_cnt_q == BCW'(R - 1));
    assign lane_last     = (lane_cnt_q == LCW'(LANES - 1));
    assign group_last    = (group_cnt_q == GCW'(GROUPS_PER_TILE - 1));
    assign expected_last = beat_last && lane_last && group_last;

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        lane_cnt_d  = lane_cnt_q;
        group_cnt_d = group_cnt_q;
        w_din_d     = w_din_q;
        din_valid_d = 1'b0;
        tile_last_d = 1'b0;
        frame_err_d = frame_err_q;

        if (state_q == FILL) begin
            if (accept) begin
                for (int l = 0; l < LANES; l++) begin
                    for (int b = 0; b < R; b++) begin
                        if (lane_cnt_q == LCW'(l) && beat_cnt_q == BCW'(b)) begin
                            w_din_d[l][b*BEAT_W +: BEAT_W] = bus.s_data;
                        end
                    end
                end
                // Framing errors are only flagged; data keeps flowing so the tile is not lost.
                if (bus.s_last != expected_last) begin
                    frame_err_d = 1'b1;
                end
                if (beat_last) begin
                    beat_cnt_d = '0;
                    if (lane_last) begin
                        lane_cnt_d = '0;
                        state_d    = HOLD;
                    end else begin
                        lane_cnt_d = lane_cnt_q + 1'b1;
                    end
                end else begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
        end else begin
            if (bus.load_ready) begin
                din_valid_d = 1'b1;
                tile_last_d = group_last;
                group_cnt_d = group_last ? '0 : group_cnt_q + 1'b1;
                state_d     = FILL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            beat_cnt_q  <= '0;
            lane_cnt_q  <= '0;
            group_cnt_q <= '0;
            w_din_q     <= '0;
            din_valid_q <= 1'b0;
            tile_last_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            lane_cnt_q  <= lane_cnt_d;
            group_cnt_q <= group_cnt_d;
            w_din_q     <= w_din_d;
            din_valid_q <= din_valid_d;
            tile_last_q <= tile_last_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.w_din     = w_din_q;
    assign bus.din_valid = din_valid_q;
    assign bus.tile_last = tile_last_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = (state_q == HOLD) || (beat_cnt_q != '0) ||
                           (lane_cnt_q != '0) || (group_cnt_q != '0);
endmodule

// File: tb/tb_pp_stream_loader.sv
// Bench for pp_stream_loader: an element-queue reference model tracks what every group,
// tile marker, s_ready, busy and frame_err must look like, driven by fixed and random streams.
module tb_pp_stream_loader;
    localparam int DW  = 16;
    localparam int BE  = 4;
    localparam int WE  = 8;
    localparam int LN  = 2;
    localparam int GPT = 4;
    localparam int BW  = BE * DW;
    localparam int WW  = WE * DW;
    localparam int GRP_ELEMS  = LN * WE;
    localparam int TILE_BEATS = GPT * LN * (WE / BE);

    logic clk = 1'b0;
    logic rst = 1'b1;

    pp_stream_loader_if #(.DATA_WIDTH(DW), .BEAT_ELEMS(BE), .WORD_ELEMS(WE), .LANES(LN)) bus ();

    pp_stream_loader #(
        .DATA_WIDTH(DW), .BEAT_ELEMS(BE), .WORD_ELEMS(WE), .LANES(LN), .GROUPS_PER_TILE(GPT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Reference model: queue of accepted elements in stream order plus tile bookkeeping.
    logic [DW-1:0] mq[$];
    int            m_beats;
    int            m_groups;
    bit            m_fe;

    logic                 obs_dv, obs_tl, obs_sr, obs_busy, obs_fe;
    bit                   obs_acc;
    logic [LN-1:0][WW-1:0] obs_w, exp_w;
    bit                   exp_w_ok, exp_tl, exp_sr, exp_busy, exp_fe;

    int          st_pulses, st_data_bad, st_tl_bad, st_sr_bad, st_busy_bad, st_fe_bad;
    logic [31:0] st_tl_mask;

    task automatic model_reset();
        mq.delete();
        m_beats  = 0;
        m_groups = 0;
        m_fe     = 1'b0;
    endtask

    task automatic stats_clear();
        st_pulses   = 0;
        st_data_bad = 0;
        st_tl_bad   = 0;
        st_sr_bad   = 0;
        st_busy_bad = 0;
        st_fe_bad   = 0;
        st_tl_mask  = '0;
    endtask

    // One clock cycle: drive inputs, observe at the falling edge, advance the model.
    task automatic cycle(input bit v, input logic [BW-1:0] d, input bit l, input bit lr);
        bit exp_last;
        bus.s_valid    = v;
        bus.s_data     = d;
        bus.s_last     = l;
        bus.load_ready = lr;
        @(negedge clk);
        obs_dv   = bus.din_valid;
        obs_tl   = bus.tile_last;
        obs_sr   = bus.s_ready;
        obs_busy = bus.busy;
        obs_fe   = bus.frame_err;
        obs_w    = bus.w_din;
        exp_fe   = m_fe;
        exp_w_ok = 1'b0;
        exp_tl   = 1'b0;
        if (obs_dv === 1'b1) begin
            exp_tl = ((m_groups % GPT) == GPT - 1);
            if (mq.size() >= GRP_ELEMS) begin
                exp_w_ok = 1'b1;
                for (int ln = 0; ln < LN; ln++)
                    for (int e = 0; e < WE; e++)
                        exp_w[ln][e*DW +: DW] = mq.pop_front();
            end
            m_groups++;
        end
        exp_sr   = !rst && (mq.size() < GRP_ELEMS);
        exp_busy = (mq.size() > 0) || ((m_groups % GPT) != 0);
        if (obs_dv === 1'b1) begin
            if (obs_tl === 1'b1 && st_pulses < 32) st_tl_mask[st_pulses] = 1'b1;
            st_pulses++;
            if (!exp_w_ok || obs_w !== exp_w) st_data_bad++;
            if (obs_tl !== exp_tl) st_tl_bad++;
        end
        if (obs_sr !== exp_sr) st_sr_bad++;
        if (obs_busy !== exp_busy) st_busy_bad++;
        if (obs_fe !== exp_fe) st_fe_bad++;
        obs_acc = v && (obs_sr === 1'b1);
        if (obs_acc) begin
            exp_last = ((m_beats % TILE_BEATS) == TILE_BEATS - 1);
            if (l != exp_last) m_fe = 1'b1;
            for (int e = 0; e < BE; e++) mq.push_back(d[e*DW +: DW]);
            m_beats++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [BW-1:0] d, input bit l, input bit lr);
        int n = 0;
        do begin
            cycle(1'b1, d, l, lr);
            n++;
        end while (!obs_acc && n < 20);
        vec_cnt++;
        if (!obs_acc) begin
            err_cnt++;
            $display("[TB] FAIL send_beat_accept: beat not accepted after %0d cycles, required acceptance", n);
        end
    endtask

    task automatic apply_reset();
        rst            = 1'b1;
        bus.s_valid    = 1'b0;
        bus.s_data     = '0;
        bus.s_last     = 1'b0;
        bus.load_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        stats_clear();
    endtask

    function automatic logic [BW-1:0] rand_beat();
        return {$urandom, $urandom};
    endfunction

    task automatic test_reset();
        rst            = 1'b1;
        bus.s_valid    = 1'b1;
        bus.s_data     = '1;
        bus.s_last     = 1'b1;
        bus.load_ready = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if (bus.s_ready !== 1'b0) begin
            err_cnt++;
            $display("[TB] FAIL reset_s_ready: got %b expected 0", bus.s_ready);
        end
        @(posedge clk);
        #1;
        rst         = 1'b0;
        bus.s_valid = 1'b0;
        model_reset();
        @(negedge clk);
        vec_cnt += 6;
        if (bus.din_valid !== 1'b0) begin err_cnt++; $display("[TB] FAIL reset_din_valid: got %b expected 0", bus.din_valid); end
        if (bus.tile_last !== 1'b0) begin err_cnt++; $display("[TB] FAIL reset_tile_last: got %b expected 0", bus.tile_last); end
        if (bus.frame_err !== 1'b0) begin err_cnt++; $display("[TB] FAIL reset_frame_err: got %b expected 0", bus.frame_err); end
        if (bus.busy !== 1'b0) begin err_cnt++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
        if (bus.w_din !== '0) begin err_cnt++; $display("[TB] FAIL reset_w_din: got %h expected 0", bus.w_din); end
        if (bus.s_ready !== 1'b1) begin err_cnt++; $display("[TB] FAIL reset_s_ready_after: got %b expected 1", bus.s_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_group();
        logic [BW-1:0]         d;
        logic [LN-1:0][WW-1:0] ex;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < BE; i++) d[i*DW +: DW] = 16'(4 * k + i);
            cycle(1'b1, d, 1'b0, 1'b1);
            vec_cnt++;
            if (!obs_acc) begin err_cnt++; $display("[TB] FAIL single_accept: beat %0d s_ready %b expected 1", k, obs_sr); end
        end
        cycle(1'b0, '0, 1'b0, 1'b1);
        vec_cnt += 3;
        if (obs_dv !== 1'b0) begin err_cnt++; $display("[TB] FAIL single_hold_dv: got %b expected 0", obs_dv); end
        if (obs_sr !== 1'b0) begin err_cnt++; $display("[TB] FAIL single_hold_ready: got %b expected 0", obs_sr); end
        if (obs_busy !== 1'b1) begin err_cnt++; $display("[TB] FAIL single_hold_busy: got %b expected 1", obs_busy); end
        cycle(1'b0, '0, 1'b0, 1'b1);
        for (int ln = 0; ln < LN; ln++)
            for (int e = 0; e < WE; e++) ex[ln][e*DW +: DW] = 16'(ln * WE + e);
        vec_cnt += 3;
        if (obs_dv !== 1'b1) begin err_cnt++; $display("[TB] FAIL single_dv: got %b expected 1", obs_dv); end
        if (obs_w !== ex) begin err_cnt++; $display("[TB] FAIL single_w_din: got %h expected %h", obs_w, ex); end
        if (obs_tl !== 1'b0) begin err_cnt++; $display("[TB] FAIL single_tile_last: got %b expected 0", obs_tl); end
        cycle(1'b0, '0, 1'b0, 1'b1);
        vec_cnt++;
        if (obs_dv !== 1'b0) begin err_cnt++; $display("[TB] FAIL single_pulse_width: got %b expected 0", obs_dv); end
    endtask

    task automatic test_tile();
        apply_reset();
        for (int b = 0; b < TILE_BEATS; b++) send_beat(rand_beat(), (b == TILE_BEATS - 1), 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b1);
        vec_cnt += 6;
        if (st_pulses != 4) begin err_cnt++; $display("[TB] FAIL tile_pulses: got %0d expected 4", st_pulses); end
        if (st_tl_mask != 32'h8) begin err_cnt++; $display("[TB] FAIL tile_last_mask: got %h expected 8", st_tl_mask); end
        if (st_data_bad != 0) begin err_cnt++; $display("[TB] FAIL tile_data: %0d bad groups, expected 0", st_data_bad); end
        if (obs_fe !== 1'b0) begin err_cnt++; $display("[TB] FAIL tile_frame_err: got %b expected 0", obs_fe); end
        if (st_busy_bad != 0) begin err_cnt++; $display("[TB] FAIL tile_busy: %0d bad cycles, expected 0", st_busy_bad); end
        if (obs_busy !== 1'b0) begin err_cnt++; $display("[TB] FAIL tile_busy_end: got %b expected 0", obs_busy); end
    endtask

    task automatic test_stall();
        logic [LN-1:0][WW-1:0] hold_w;
        apply_reset();
        for (int b = 0; b < 4; b++) send_beat(rand_beat(), 1'b0, 1'b0);
        for (int ln = 0; ln < LN; ln++)
            for (int e = 0; e < WE; e++) hold_w[ln][e*DW +: DW] = mq[ln * WE + e];
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, rand_beat(), 1'b0, 1'b0);
            vec_cnt += 3;
            if (obs_sr !== 1'b0) begin err_cnt++; $display("[TB] FAIL stall_ready: cycle %0d got %b expected 0", i, obs_sr); end
            if (obs_dv !== 1'b0) begin err_cnt++; $display("[TB] FAIL stall_dv: cycle %0d got %b expected 0", i, obs_dv); end
            if (obs_w !== hold_w) begin err_cnt++; $display("[TB] FAIL stall_w_din: cycle %0d got %h expected %h", i, obs_w, hold_w); end
        end
        stats_clear();
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b1);
        vec_cnt += 2;
        if (st_pulses != 1) begin err_cnt++; $display("[TB] FAIL stall_release_pulses: got %0d expected 1", st_pulses); end
        if (st_data_bad != 0) begin err_cnt++; $display("[TB] FAIL stall_release_data: %0d bad groups, expected 0", st_data_bad); end
    endtask

    task automatic test_frame_err();
        apply_reset();
        for (int b = 0; b < TILE_BEATS; b++) send_beat(rand_beat(), (b == 4) || (b == TILE_BEATS - 1), 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b0, 1'b1);
        vec_cnt += 5;
        if (obs_fe !== 1'b1) begin err_cnt++; $display("[TB] FAIL frame_err_sticky: got %b expected 1", obs_fe); end
        if (st_fe_bad != 0) begin err_cnt++; $display("[TB] FAIL frame_err_timing: %0d bad cycles, expected 0", st_fe_bad); end
        if (st_pulses != 4) begin err_cnt++; $display("[TB] FAIL frame_err_pulses: got %0d expected 4", st_pulses); end
        if (st_data_bad != 0) begin err_cnt++; $display("[TB] FAIL frame_err_data: %0d bad groups, expected 0", st_data_bad); end
        if (st_tl_mask != 32'h8) begin err_cnt++; $display("[TB] FAIL frame_err_tile_last: got %h expected 8", st_tl_mask); end
    endtask

    task automatic test_reset_midgroup();
        apply_reset();
        send_beat(rand_beat(), 1'b1, 1'b1);
        send_beat(rand_beat(), 1'b0, 1'b1);
        send_beat(rand_beat(), 1'b0, 1'b1);
        rst = 1'b1;
        bus.s_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        stats_clear();
        cycle(1'b0, '0, 1'b0, 1'b0);
        vec_cnt += 3;
        if (obs_busy !== 1'b0) begin err_cnt++; $display("[TB] FAIL midreset_busy: got %b expected 0", obs_busy); end
        if (obs_sr !== 1'b1) begin err_cnt++; $display("[TB] FAIL midreset_ready: got %b expected 1", obs_sr); end
        if (obs_fe !== 1'b0) begin err_cnt++; $display("[TB] FAIL midreset_frame_err: got %b expected 0", obs_fe); end
        for (int b = 0; b < 4; b++) send_beat(rand_beat(), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b1);
        vec_cnt += 3;
        if (st_pulses != 1) begin err_cnt++; $display("[TB] FAIL midreset_pulses: got %0d expected 1", st_pulses); end
        if (st_data_bad != 0) begin err_cnt++; $display("[TB] FAIL midreset_data: %0d bad groups, expected 0", st_data_bad); end
        if (st_tl_bad != 0) begin err_cnt++; $display("[TB] FAIL midreset_tile_last: %0d bad, expected 0", st_tl_bad); end
    endtask

    task automatic test_random();
        int cyc = 0;
        apply_reset();
        while (m_beats < 8 * TILE_BEATS && cyc < 4000) begin
            cycle(($urandom % 2) == 1, rand_beat(), ((m_beats % TILE_BEATS) == TILE_BEATS - 1),
                  ($urandom % 2) == 1);
            cyc++;
        end
        cyc = 0;
        while (m_groups < 8 * GPT && cyc < 50) begin
            cycle(1'b0, '0, 1'b0, 1'b1);
            cyc++;
        end
        vec_cnt += 9;
        if (m_beats != 8 * TILE_BEATS) begin err_cnt++; $display("[TB] FAIL random_beats: got %0d expected %0d", m_beats, 8 * TILE_BEATS); end
        if (st_pulses != 8 * GPT) begin err_cnt++; $display("[TB] FAIL random_pulses: got %0d expected %0d", st_pulses, 8 * GPT); end
        if (st_data_bad != 0) begin err_cnt++; $display("[TB] FAIL random_data: %0d bad groups, expected 0", st_data_bad); end
        if (st_tl_bad != 0) begin err_cnt++; $display("[TB] FAIL random_tile_last: %0d bad, expected 0", st_tl_bad); end
        if (st_sr_bad != 0) begin err_cnt++; $display("[TB] FAIL random_ready: %0d bad cycles, expected 0", st_sr_bad); end
        if (st_busy_bad != 0) begin err_cnt++; $display("[TB] FAIL random_busy: %0d bad cycles, expected 0", st_busy_bad); end
        if (st_fe_bad != 0) begin err_cnt++; $display("[TB] FAIL random_frame_err: %0d bad cycles, expected 0", st_fe_bad); end
        if (mq.size() != 0) begin err_cnt++; $display("[TB] FAIL random_leftover: %0d elements pending, expected 0", mq.size()); end
        if (obs_fe !== 1'b0) begin err_cnt++; $display("[TB] FAIL random_frame_err_end: got %b expected 0", obs_fe); end
    endtask

    initial begin
        model_reset();
        stats_clear();
        test_reset();
        test_single_group();
        test_tile();
        test_stall();
        test_frame_err();
        test_reset_midgroup();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
